// File: rtl/uart_rx_sampler.sv
// UART receive engine: synchronizes Rx, detects the start edge, majority-votes the
// three centre strobes of each bit and reports the byte with parity/frame status.
module uart_rx_sampler #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Rx_i,
    input  logic                 AcqSig_i,
    input  logic [4:0]           AcqPerBit_i,
    input  logic                 ParityEn_i,
    input  logic                 ParityOdd_i,
    output logic                 BaudEn_o,
    output logic [DATA_BITS-1:0] RxData_o,
    output logic                 RxValid_o,
    output logic                 ParityErr_o,
    output logic                 FrameErr_o,
    output logic                 Busy_o
);

    localparam int unsigned CntW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [4:0]             n_q;
    logic [4:0]             k_q;
    logic                   s_lo_q;
    logic                   s_mid_q;
    logic [DATA_BITS-1:0]   shreg_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   par_acc_q;
    logic                   par_err_q;

    logic       rx_s;
    logic [4:0] n_clamped;
    logic [4:0] mid;
    logic       at_lo;
    logic       at_mid;
    logic       at_hi;
    logic       at_end;
    logic       vote;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Rx_i};
        end
    end

    assign rx_s      = sync_q[SYNC_STAGES-1];
    assign n_clamped = (AcqPerBit_i < 5'd3) ? 5'd3 : AcqPerBit_i;
    assign mid       = n_q >> 1;
    assign at_lo     = (k_q == mid - 5'd1);
    assign at_mid    = (k_q == mid);
    assign at_hi     = (k_q == mid + 5'd1);
    assign at_end    = (k_q == n_q - 5'd1);
    // Third vote sample is taken live on the k = m+1 strobe.
    assign vote      = (s_lo_q & s_mid_q) | (s_lo_q & rx_s) | (s_mid_q & rx_s);
    assign Busy_o    = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            prev_q      <= 1'b1;
            n_q         <= 5'd3;
            k_q         <= '0;
            s_lo_q      <= 1'b1;
            s_mid_q     <= 1'b1;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            BaudEn_o    <= 1'b0;
            RxData_o    <= '0;
            RxValid_o   <= 1'b0;
            ParityErr_o <= 1'b0;
            FrameErr_o  <= 1'b0;
        end else begin
            RxValid_o <= 1'b0;
            prev_q    <= rx_s;
            if (state_q == StIdle) begin
                if (prev_q && !rx_s) begin
                    state_q   <= StStart;
                    BaudEn_o  <= 1'b1;
                    k_q       <= '0;
                    n_q       <= n_clamped;
                    par_en_q  <= ParityEn_i;
                    par_odd_q <= ParityOdd_i;
                    bit_cnt_q <= '0;
                    par_acc_q <= 1'b0;
                    par_err_q <= 1'b0;
                end
            end else begin
                if (AcqSig_i && !RxValid_o) begin
                    k_q <= at_end ? 5'd0 : k_q + 5'd1;
                    if (at_lo) s_lo_q <= rx_s;
                    if (at_mid) s_mid_q <= rx_s;
                    unique case (state_q)
                        StStart: begin
                            if (at_hi && vote) begin
                                state_q  <= StIdle;
                                BaudEn_o <= 1'b0;
                            end else if (at_end) begin
                                state_q <= StData;
                            end
                        end
                        StData: begin
                            if (at_hi) begin
                                shreg_q   <= {vote, shreg_q[DATA_BITS-1:1]};
                                par_acc_q <= par_acc_q ^ vote;
                            end
                            if (at_end) begin
                                bit_cnt_q <= bit_cnt_q + CntW'(1);
                                if (bit_cnt_q == CntW'(DATA_BITS - 1)) begin
                                    state_q <= par_en_q ? StParity : StStop;
                                end
                            end
                        end
                        StParity: begin
                            if (at_hi) par_err_q <= ((par_acc_q ^ vote) != par_odd_q);
                            if (at_end) state_q <= StStop;
                        end
                        StStop: begin
                            // Early exit: report as soon as the stop vote is known.
                            if (at_hi) begin
                                RxData_o    <= shreg_q;
                                FrameErr_o  <= ~vote;
                                ParityErr_o <= par_en_q & par_err_q;
                                RxValid_o   <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                if (RxValid_o) begin
                    state_q  <= StIdle;
                    BaudEn_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Self-checking bench for uart_rx_sampler: drives serial frames against a bench baud
// generator and compares each RxValid_o report with a scoreboard of expected results.
module tb_uart_rx_sampler;

    localparam int unsigned DB = 8;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          Rx_i;
    logic          AcqSig_i;
    logic [4:0]    AcqPerBit_i;
    logic          ParityEn_i;
    logic          ParityOdd_i;
    logic          BaudEn_o;
    logic [DB-1:0] RxData_o;
    logic          RxValid_o;
    logic          ParityErr_o;
    logic          FrameErr_o;
    logic          Busy_o;

    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_pulse = 0;
    int   n_push = 0;
    int   per    = 16;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] gen_cnt;

    uart_rx_sampler #(
        .DATA_BITS  (DB),
        .SYNC_STAGES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .Rx_i       (Rx_i),
        .AcqSig_i   (AcqSig_i),
        .AcqPerBit_i(AcqPerBit_i),
        .ParityEn_i (ParityEn_i),
        .ParityOdd_i(ParityOdd_i),
        .BaudEn_o   (BaudEn_o),
        .RxData_o   (RxData_o),
        .RxValid_o  (RxValid_o),
        .ParityErr_o(ParityErr_o),
        .FrameErr_o (FrameErr_o),
        .Busy_o     (Busy_o)
    );

    always #5 clk = ~clk;

    // Baud generator model: starts counting when enabled, strobes mid-way through each period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) gen_cnt <= '0;
        else if (!BaudEn_o) gen_cnt <= '0;
        else if (gen_cnt == 8'(per - 1)) gen_cnt <= '0;
        else gen_cnt <= gen_cnt + 8'd1;
    end
    assign AcqSig_i = BaudEn_o && (gen_cnt == 8'(per / 2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            Rx_i = 1'b1;
        end
    endtask

    task automatic check_reset_values();
        check("rst_baud_en", 32'(BaudEn_o), 32'd0);
        check("rst_rx_data", 32'(RxData_o), 32'd0);
        check("rst_rx_valid", 32'(RxValid_o), 32'd0);
        check("rst_parity_err", 32'(ParityErr_o), 32'd0);
        check("rst_frame_err", 32'(FrameErr_o), 32'd0);
        check("rst_busy", 32'(Busy_o), 32'd0);
    endtask

    // glitch_bit: frame bit whose centre sample is inverted (-1 none).
    // rst_bit: frame bit in whose middle reset is pulsed and the frame abandoned (-1 none).
    task automatic send_frame(input logic [7:0] data, input int n, input logic pen,
                              input logic podd, input logic pbit, input logic stop,
                              input int glitch_bit, input int rst_bit, input logic expect_out);
        logic bits [12];
        exp_t e;
        int   nb;
        int   n_eff;
        int   bit_len;
        int   gc;
        logic v;
        n_eff       = (n < 3) ? 3 : n;
        bit_len     = n_eff * per;
        gc          = glitch_bit * bit_len + (n_eff / 2) * per + per / 2 + 1;
        nb          = 0;
        bits[nb++]  = 1'b0;
        for (int i = 0; i < DB; i++) bits[nb++] = data[i];
        if (pen) bits[nb++] = pbit;
        bits[nb++]  = stop;
        AcqPerBit_i = 5'(n);
        ParityEn_i  = pen;
        ParityOdd_i = podd;
        if (expect_out) begin
            e.data = data;
            e.perr = pen ? (((^data) ^ pbit) != podd) : 1'b0;
            e.ferr = ~stop;
            sb.push_back(e);
            n_push++;
        end
        for (int c = 0; c < nb * bit_len; c++) begin
            @(negedge clk);
            v = bits[c / bit_len];
            if (glitch_bit >= 0 && c >= gc - 4 && c <= gc + 4) v = ~v;
            Rx_i = v;
            if (c == bit_len) begin
                check("busy_in_frame", 32'(Busy_o), 32'd1);
                check("baud_en_in_frame", 32'(BaudEn_o), 32'd1);
            end
            if (rst_bit >= 0 && c == rst_bit * bit_len + bit_len / 2) begin
                Rx_i = 1'b1;
                rst  = 1'b1;
                @(negedge clk);
                check_reset_values();
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
    endtask

    // Scoreboard consumer: every RxValid_o pulse pops one expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (RxValid_o === 1'b1) begin
                n_pulse++;
                check("valid_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("rx_data", 32'(RxData_o), 32'(mon_e.data));
                    check("parity_err", 32'(ParityErr_o), 32'(mon_e.perr));
                    check("frame_err", 32'(FrameErr_o), 32'(mon_e.ferr));
                end
                @(negedge clk);
                check("valid_width", 32'(RxValid_o), 32'd0);
                check("baud_en_drop", 32'(BaudEn_o), 32'd0);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        Rx_i        = 1'b1;
        AcqPerBit_i = 5'd8;
        ParityEn_i  = 1'b0;
        ParityOdd_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        idle(20);

        // 8N1, N=8
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        idle(50);

        // Parity: even ok, even bad, odd ok
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        idle(50);
        send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1);
        idle(50);
        send_frame(8'h3C, 8, 1'b1, 1'b1, 1'b1, 1'b1, -1, -1, 1'b1);
        idle(50);

        // False start: line low across strobes 0..2 only
        AcqPerBit_i = 5'd8;
        ParityEn_i  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            Rx_i = (c < 48) ? 1'b0 : 1'b1;
            if (c == 20) begin
                check("false_start_baud_up", 32'(BaudEn_o), 32'd1);
                check("false_start_busy", 32'(Busy_o), 32'd1);
            end
            if (c == 150) begin
                check("false_start_baud_down", 32'(BaudEn_o), 32'd0);
                check("false_start_idle", 32'(Busy_o), 32'd0);
                check("false_start_data_held", 32'(RxData_o), 32'h3C);
            end
        end
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        idle(50);

        // Stop bit low, then a clean frame after the line idles high
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, -1, 1'b1);
        idle(100);
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        idle(50);

        // Centre-sample glitch on data bit 3 (frame bit 4)
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 4, -1, 1'b1);
        idle(50);

        // N below 3 is clamped to 3
        per = 40;
        send_frame(8'hC3, 1, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        idle(60);
        per = 16;
        idle(10);

        // Back-to-back frames, then reset during data bit 5 of a third
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        send_frame(8'h99, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 6, 1'b0);
        idle(50);
        send_frame(8'h6E, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, -1, 1'b1);
        idle(300);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("pulse_count", 32'(n_pulse), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
